// File: rtl/sound_mixer_ctl_if.sv
// I/O port bundle for the mixer at 224h (index) / 225h (data).
// Host side drives strobes and write data; the mixer returns readdata.
interface sound_mixer_ctl_if;
    logic       mix_cs;
    logic       address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (
        output mix_cs, address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  mix_cs, address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/sound_mixer_ctl.sv
// SB Pro mixer: volume registers plus a one-multiplier sequential stereo mix.
// Optional SOUND_MIXER_MONO_EN adds register 0x0E and a mono-fold state.
module sound_mixer_ctl #(
    parameter int SAT_MAX = 32767,
    parameter int SAT_MIN = -32768
) (
    input  logic                clk,
    input  logic                rst,
    sound_mixer_ctl_if.slave    bus,
    input  logic                ce_sample,
    input  logic signed [15:0]  dsp_l,
    input  logic signed [15:0]  dsp_r,
    input  logic signed [15:0]  opl_l,
    input  logic signed [15:0]  opl_r,
    input  logic signed [15:0]  cms_l,
    input  logic signed [15:0]  cms_r,
    output logic signed [15:0]  sample_l,
    output logic signed [15:0]  sample_r,
    output logic                sample_valid,
    output logic                busy
);

`ifdef SOUND_MIXER_MONO_EN
    localparam bit MONO_EN = 1'b1;
`else
    localparam bit MONO_EN = 1'b0;
`endif

    localparam logic [7:0] VOL_RST  = 8'hEE;
    localparam logic [7:0] MODE_RST = 8'h02;
    localparam logic signed [19:0] SAT_HI = 20'(SAT_MAX);
    localparam logic signed [19:0] SAT_LO = 20'(SAT_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MIX,
        S_MONO,
        S_OUT
    } state_t;

    state_t state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [7:0] index_q, index_d;
    logic [7:0] vol_dsp_q, vol_dsp_d;
    logic [7:0] vol_master_q, vol_master_d;
    logic [7:0] vol_fm_q, vol_fm_d;
    logic [7:0] vol_cms_q, vol_cms_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] readdata_q, readdata_d;

    logic [7:0] snap_vdsp_q, snap_vdsp_d;
    logic [7:0] snap_vmst_q, snap_vmst_d;
    logic [7:0] snap_vfm_q, snap_vfm_d;
    logic [7:0] snap_vcms_q, snap_vcms_d;
    logic       snap_stereo_q, snap_stereo_d;
    logic signed [15:0] snap_dl_q, snap_dl_d;
    logic signed [15:0] snap_dr_q, snap_dr_d;
    logic signed [15:0] snap_ol_q, snap_ol_d;
    logic signed [15:0] snap_or_q, snap_or_d;
    logic signed [15:0] snap_cl_q, snap_cl_d;
    logic signed [15:0] snap_cr_q, snap_cr_d;

    logic signed [17:0] acc_q, acc_d;
    logic signed [15:0] sat_l_q, sat_l_d;
    logic signed [15:0] sat_r_q, sat_r_d;
    logic signed [15:0] sample_l_q, sample_l_d;
    logic signed [15:0] sample_r_q, sample_r_d;
    logic               sample_valid_q, sample_valid_d;

    logic [7:0]         reg_rd;
    logic [7:0]         vol_sel;
    logic [3:0]         nib;
    logic [4:0]         gain;
    logic signed [15:0] src_x;
    logic signed [17:0] mul_a;
    logic signed [23:0] a_ext;
    logic signed [23:0] g_ext;
    logic signed [23:0] mul_p;
    logic signed [19:0] mul_t;
    logic signed [15:0] sat_val;
    logic signed [16:0] mono_sum;
    logic signed [15:0] mono_val;

    always_comb begin
        reg_rd = 8'hFF;
        case (index_q)
            8'h04:   reg_rd = vol_dsp_q;
            8'h22:   reg_rd = vol_master_q;
            8'h26:   reg_rd = vol_fm_q;
            8'h2E:   reg_rd = vol_cms_q;
            8'h0E:   reg_rd = MONO_EN ? mode_q : 8'hFF;
            default: reg_rd = 8'hFF;
        endcase
    end

    // step[2] picks the channel, step[1:0] the source; slot 3 is master
    always_comb begin
        vol_sel = snap_vmst_q;
        src_x   = '0;
        case (step_q[1:0])
            2'd0: begin
                vol_sel = snap_vdsp_q;
                src_x   = step_q[2] ? snap_dr_q : snap_dl_q;
            end
            2'd1: begin
                vol_sel = snap_vfm_q;
                src_x   = step_q[2] ? snap_or_q : snap_ol_q;
            end
            2'd2: begin
                vol_sel = snap_vcms_q;
                src_x   = step_q[2] ? snap_cr_q : snap_cl_q;
            end
            default: begin
                vol_sel = snap_vmst_q;
                src_x   = '0;
            end
        endcase
        nib   = step_q[2] ? vol_sel[3:0] : vol_sel[7:4];
        gain  = {1'b0, nib} + 5'd1;
        mul_a = (step_q[1:0] == 2'd3) ? acc_q : {{2{src_x[15]}}, src_x};
        a_ext = {{6{mul_a[17]}}, mul_a};
        g_ext = {19'd0, gain};
        mul_p = a_ext * g_ext;
        mul_t = 20'(mul_p >>> 4);
        if (mul_t > SAT_HI) begin
            sat_val = SAT_HI[15:0];
        end else if (mul_t < SAT_LO) begin
            sat_val = SAT_LO[15:0];
        end else begin
            sat_val = mul_t[15:0];
        end
        mono_sum = {sat_l_q[15], sat_l_q} + {sat_r_q[15], sat_r_q};
        mono_val = 16'(mono_sum >>> 1);
    end

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        index_d        = index_q;
        vol_dsp_d      = vol_dsp_q;
        vol_master_d   = vol_master_q;
        vol_fm_d       = vol_fm_q;
        vol_cms_d      = vol_cms_q;
        mode_d         = mode_q;
        readdata_d     = readdata_q;
        snap_vdsp_d    = snap_vdsp_q;
        snap_vmst_d    = snap_vmst_q;
        snap_vfm_d     = snap_vfm_q;
        snap_vcms_d    = snap_vcms_q;
        snap_stereo_d  = snap_stereo_q;
        snap_dl_d      = snap_dl_q;
        snap_dr_d      = snap_dr_q;
        snap_ol_d      = snap_ol_q;
        snap_or_d      = snap_or_q;
        snap_cl_d      = snap_cl_q;
        snap_cr_d      = snap_cr_q;
        acc_d          = acc_q;
        sat_l_d        = sat_l_q;
        sat_r_d        = sat_r_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = 1'b0;

        if (bus.mix_cs && bus.write) begin
            if (!bus.address) begin
                index_d = bus.writedata;
            end else begin
                case (index_q)
                    8'h00: begin
                        vol_dsp_d    = VOL_RST;
                        vol_master_d = VOL_RST;
                        vol_fm_d     = VOL_RST;
                        vol_cms_d    = VOL_RST;
                    end
                    8'h04:   vol_dsp_d    = bus.writedata;
                    8'h22:   vol_master_d = bus.writedata;
                    8'h26:   vol_fm_d     = bus.writedata;
                    8'h2E:   vol_cms_d    = bus.writedata;
                    8'h0E:   if (MONO_EN) mode_d = bus.writedata;
                    default: ;
                endcase
            end
        end

        if (bus.mix_cs && bus.read) begin
            readdata_d = bus.address ? reg_rd : index_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ce_sample) begin
                    snap_vdsp_d   = vol_dsp_q;
                    snap_vmst_d   = vol_master_q;
                    snap_vfm_d    = vol_fm_q;
                    snap_vcms_d   = vol_cms_q;
                    snap_stereo_d = mode_q[1];
                    snap_dl_d     = dsp_l;
                    snap_dr_d     = dsp_r;
                    snap_ol_d     = opl_l;
                    snap_or_d     = opl_r;
                    snap_cl_d     = cms_l;
                    snap_cr_d     = cms_r;
                    step_d        = 3'd0;
                    state_d       = S_MIX;
                end
            end
            S_MIX: begin
                if (step_q[1:0] == 2'd3) begin
                    if (step_q[2]) sat_r_d = sat_val;
                    else           sat_l_d = sat_val;
                end else begin
                    acc_d = ((step_q[1:0] == 2'd0) ? 18'sd0 : acc_q)
                          + mul_t[17:0];
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = MONO_EN ? S_MONO : S_OUT;
                end
            end
            S_MONO: begin
                if (!snap_stereo_q) begin
                    sat_l_d = mono_val;
                    sat_r_d = mono_val;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                sample_l_d     = sat_l_q;
                sample_r_d     = sat_r_q;
                sample_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            step_q         <= '0;
            index_q        <= 8'h00;
            vol_dsp_q      <= VOL_RST;
            vol_master_q   <= VOL_RST;
            vol_fm_q       <= VOL_RST;
            vol_cms_q      <= VOL_RST;
            mode_q         <= MODE_RST;
            readdata_q     <= '0;
            snap_vdsp_q    <= '0;
            snap_vmst_q    <= '0;
            snap_vfm_q     <= '0;
            snap_vcms_q    <= '0;
            snap_stereo_q  <= 1'b1;
            snap_dl_q      <= '0;
            snap_dr_q      <= '0;
            snap_ol_q      <= '0;
            snap_or_q      <= '0;
            snap_cl_q      <= '0;
            snap_cr_q      <= '0;
            acc_q          <= '0;
            sat_l_q        <= '0;
            sat_r_q        <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            index_q        <= index_d;
            vol_dsp_q      <= vol_dsp_d;
            vol_master_q   <= vol_master_d;
            vol_fm_q       <= vol_fm_d;
            vol_cms_q      <= vol_cms_d;
            mode_q         <= mode_d;
            readdata_q     <= readdata_d;
            snap_vdsp_q    <= snap_vdsp_d;
            snap_vmst_q    <= snap_vmst_d;
            snap_vfm_q     <= snap_vfm_d;
            snap_vcms_q    <= snap_vcms_d;
            snap_stereo_q  <= snap_stereo_d;
            snap_dl_q      <= snap_dl_d;
            snap_dr_q      <= snap_dr_d;
            snap_ol_q      <= snap_ol_d;
            snap_or_q      <= snap_or_d;
            snap_cl_q      <= snap_cl_d;
            snap_cr_q      <= snap_cr_d;
            acc_q          <= acc_d;
            sat_l_q        <= sat_l_d;
            sat_r_q        <= sat_r_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign bus.readdata  = readdata_q;
    assign sample_l      = sample_l_q;
    assign sample_r      = sample_r_q;
    assign sample_valid  = sample_valid_q;
    assign busy          = (state_q == S_MIX) || (state_q == S_MONO);

endmodule
